// File: rtl/matrix_rx_loader_if.sv
// matrix_rx_loader_if: UART byte input and matrix-multiplier side outputs of the loader
interface matrix_rx_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [26:0] matrixA;
   logic [26:0] matrixB;
   logic        start;
   logic        busy;
   logic        frame_err;
   logic        rx_drop;
   logic [7:0]  frame_cnt;
   modport master (
      output rx_data, rx_valid,
      input  matrixA, matrixB, start, busy, frame_err, rx_drop, frame_cnt
   );
   modport slave (
      input  rx_data, rx_valid,
      output matrixA, matrixB, start, busy, frame_err, rx_drop, frame_cnt
   );
endinterface

// File: rtl/matrix_rx_loader.sv
// matrix_rx_loader: parses header + 9 A + 9 B element bytes and fires the 3x3 multiplier
module matrix_rx_loader #(
   parameter logic [7:0] HEADER         = 8'hA5,
   parameter int         TIMEOUT_CYCLES = 100000,
   parameter int         START_CYCLES   = 2
) (
   input logic               clk,
   input logic               rst,
   matrix_rx_loader_if.slave bus
);
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam int FW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [FW-1:0] FIRE_LAST = FW'(START_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, FIRE} state_t;
   state_t        r_state, w_next;
   logic [3:0]    r_idx, w_idx;
   logic [TW-1:0] r_tcnt;
   logic [FW-1:0] r_fcnt;
   logic [26:0]   r_sh_a, r_sh_b, r_mat_a, r_mat_b;
   logic [7:0]    r_cnt;
   logic          r_err, r_drop;
   logic          w_err, w_drop, w_fire, w_tclr, w_ld_a, w_ld_b;
   logic          w_hdr, w_legal, w_last, w_in_load;
   assign w_hdr     = bus.rx_data == HEADER;
   assign w_legal   = bus.rx_data[7:3] == 5'd0;
   assign w_last    = r_idx == 4'd8;
   assign w_in_load = (w_next == LOAD_A) || (w_next == LOAD_B);
   // state register; reset abandons any partial frame and drops start at once
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end
   // next state and per-byte decisions; resync header wins over the legality check
   always_comb begin
      w_next = r_state;
      w_idx  = r_idx;
      w_err  = 1'b0;
      w_drop = 1'b0;
      w_fire = 1'b0;
      w_tclr = 1'b0;
      w_ld_a = 1'b0;
      w_ld_b = 1'b0;
      case (r_state)
         IDLE: if (bus.rx_valid && w_hdr) begin
            w_next = LOAD_A;
            w_idx  = '0;
            w_tclr = 1'b1;
         end
         LOAD_A, LOAD_B: if (bus.rx_valid) begin
            w_tclr = 1'b1;
            if (w_hdr) begin
               w_err  = 1'b1;
               w_next = LOAD_A;
               w_idx  = '0;
            end else if (!w_legal) begin
               w_err  = 1'b1;
               w_next = IDLE;
            end else begin
               w_ld_a = r_state == LOAD_A;
               w_ld_b = r_state == LOAD_B;
               w_idx  = w_last ? 4'd0 : r_idx + 4'd1;
               w_fire = w_last && (r_state == LOAD_B);
               if (w_last) w_next = (r_state == LOAD_A) ? LOAD_B : FIRE;
            end
         end else if (r_tcnt == TO_LAST) begin
            w_err  = 1'b1;
            w_next = IDLE;
         end
         FIRE: begin
            w_drop = bus.rx_valid;
            if (r_fcnt == FIRE_LAST) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end
   // datapath: shadow capture, atomic matrix update on FIRE entry, counters and pulses
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_idx   <= '0;
         r_tcnt  <= '0;
         r_fcnt  <= '0;
         r_sh_a  <= '0;
         r_sh_b  <= '0;
         r_mat_a <= '0;
         r_mat_b <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_drop  <= 1'b0;
      end else begin
         r_idx  <= w_idx;
         r_err  <= w_err;
         r_drop <= w_drop;
         r_tcnt <= (w_tclr || !w_in_load) ? '0 : r_tcnt + TW'(1);
         r_fcnt <= (r_state == FIRE) ? r_fcnt + FW'(1) : '0;
         if (w_ld_a) r_sh_a[r_idx*3 +: 3] <= bus.rx_data[2:0];
         if (w_ld_b) r_sh_b[r_idx*3 +: 3] <= bus.rx_data[2:0];
         if (w_fire) begin
            r_mat_a <= r_sh_a;
            r_mat_b <= {bus.rx_data[2:0], r_sh_b[23:0]};
            r_cnt   <= r_cnt + 8'd1;
         end
      end
   end
   assign bus.matrixA   = r_mat_a;
   assign bus.matrixB   = r_mat_b;
   assign bus.start     = r_state == FIRE;
   assign bus.busy      = r_state != IDLE;
   assign bus.frame_err = r_err;
   assign bus.rx_drop   = r_drop;
   assign bus.frame_cnt = r_cnt;
endmodule

// File: tb/tb_matrix_rx_loader.sv
// tb_matrix_rx_loader: scoreboard bench for the matrix frame loader
module tb_matrix_rx_loader;
   localparam logic [7:0] HDR = 8'hA5;
   typedef struct {
      logic [26:0] a;
      logic [26:0] b;
      logic [7:0]  cnt;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   n_err  = 0;
   int   n_drop = 0;
   int   run    = 0;
   logic prev_start = 1'b0;
   logic [7:0] exp_cnt = 8'd0;
   exp_t q[$];
   matrix_rx_loader_if bus ();
   matrix_rx_loader #(.HEADER(HDR), .TIMEOUT_CYCLES(16), .START_CYCLES(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic send_byte(input logic [7:0] b);
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
   endtask
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic push_exp(input logic [26:0] a, input logic [26:0] b);
      exp_t e;
      exp_cnt = exp_cnt + 8'd1;
      e.a = a;
      e.b = b;
      e.cnt = exp_cnt;
      q.push_back(e);
   endtask
   task automatic send_frame(input logic [26:0] a, input logic [26:0] b);
      push_exp(a, b);
      send_byte(HDR);
      for (int k = 0; k < 9; k++) send_byte({5'd0, a[k*3 +: 3]});
      for (int k = 0; k < 9; k++) send_byte({5'd0, b[k*3 +: 3]});
   endtask
   // output monitor: pops the scoreboard on each start rise and checks start width
   always @(negedge clk) begin
      exp_t e;
      if (bus.frame_err === 1'b1) n_err++;
      if (bus.rx_drop === 1'b1) n_drop++;
      if (bus.start === 1'b1 && !prev_start) begin
         if (q.size() == 0) chk("start_unexpected", 1, 0);
         else begin
            e = q.pop_front();
            chk("matrixA", bus.matrixA, e.a);
            chk("matrixB", bus.matrixB, e.b);
            chk("frame_cnt", bus.frame_cnt, e.cnt);
         end
         run = 0;
      end
      if (bus.start === 1'b1) run++;
      else if (prev_start) chk("start_width", run, 2);
      prev_start = bus.start === 1'b1;
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, required finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int e0;
      bus.rx_data  = 8'd0;
      bus.rx_valid = 1'b0;
      #2 rst = 1'b0;
      idle(2);
      chk("rst_matrixA", bus.matrixA, 0);
      chk("rst_matrixB", bus.matrixB, 0);
      chk("rst_start", bus.start, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_frame_err", bus.frame_err, 0);
      chk("rst_rx_drop", bus.rx_drop, 0);
      chk("rst_frame_cnt", bus.frame_cnt, 0);
      rst = 1'b1;
      idle(2);
      send_frame(27'h1001001, 27'h7FFFFFF);
      chk("t2_start_on", bus.start, 1);
      chk("t2_busy_fire", bus.busy, 1);
      idle(2);
      chk("t2_start_off", bus.start, 0);
      chk("t2_busy_off", bus.busy, 0);
      chk("t2_frame_cnt", bus.frame_cnt, 1);
      send_byte(HDR);
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      send_byte(8'h08);
      chk("t3_err_on", bus.frame_err, 1);
      chk("t3_busy", bus.busy, 0);
      idle(1);
      chk("t3_err_off", bus.frame_err, 0);
      chk("t3_matrixA_hold", bus.matrixA, 27'h1001001);
      chk("t3_matrixB_hold", bus.matrixB, 27'h7FFFFFF);
      send_byte(8'h33);
      chk("t3_stray_err", bus.frame_err, 0);
      chk("t3_stray_busy", bus.busy, 0);
      idle(1);
      e0 = n_err;
      send_byte(HDR);
      for (int k = 0; k < 11; k++) send_byte(8'h05);
      send_byte(HDR);
      chk("t4_resync_err", bus.frame_err, 1);
      chk("t4_resync_busy", bus.busy, 1);
      push_exp(27'h00FAC688, 27'h7053977);
      for (int k = 0; k < 9; k++) send_byte((k == 8) ? 8'd0 : 8'(k));
      for (int k = 0; k < 9; k++) send_byte((k == 8) ? 8'd7 : 8'(7 - k));
      idle(3);
      chk("t4_err_count", n_err - e0, 1);
      chk("t4_frame_cnt", bus.frame_cnt, 2);
      send_byte(HDR);
      for (int k = 0; k < 5; k++) send_byte(8'h02);
      idle(15);
      chk("t5_no_early_timeout", bus.frame_err, 0);
      chk("t5_busy_waiting", bus.busy, 1);
      idle(1);
      chk("t5_timeout_err", bus.frame_err, 1);
      chk("t5_timeout_idle", bus.busy, 0);
      idle(1);
      push_exp(27'h2492492, 27'h1249249);
      send_byte(HDR);
      for (int k = 0; k < 5; k++) send_byte(8'h02);
      idle(15);
      send_byte(8'h02);
      chk("t5_late_byte_err", bus.frame_err, 0);
      chk("t5_late_byte_busy", bus.busy, 1);
      for (int k = 0; k < 3; k++) send_byte(8'h02);
      for (int k = 0; k < 9; k++) send_byte(8'h01);
      idle(3);
      chk("t5_frame_cnt", bus.frame_cnt, 3);
      send_frame(27'($urandom()), 27'($urandom()));
      send_byte(HDR);
      chk("t6_drop_on", bus.rx_drop, 1);
      chk("t6_start_held", bus.start, 1);
      idle(1);
      chk("t6_drop_off", bus.rx_drop, 0);
      chk("t6_back_idle", bus.busy, 0);
      idle(1);
      send_byte(HDR);
      for (int k = 0; k < 9; k++) send_byte(8'h03);
      for (int k = 0; k < 4; k++) send_byte(8'h04);
      rst = 1'b0;
      #1;
      chk("t1_rst_busy", bus.busy, 0);
      chk("t1_rst_start", bus.start, 0);
      chk("t1_rst_matrixA", bus.matrixA, 0);
      chk("t1_rst_matrixB", bus.matrixB, 0);
      chk("t1_rst_frame_cnt", bus.frame_cnt, 0);
      exp_cnt = 8'd0;
      idle(2);
      rst = 1'b1;
      idle(1);
      send_frame(27'h5A5A5A5, 27'h3C3C3C3);
      idle(2);
      chk("t1_frame_cnt", bus.frame_cnt, 1);
      for (int f = 0; f < 255; f++) begin
         send_frame(27'($urandom()), 27'($urandom()));
         idle(2);
      end
      chk("t6_wrap_cnt", bus.frame_cnt, 0);
      idle(3);
      chk("sb_empty", q.size(), 0);
      chk("drop_total", n_drop, 1);
      chk("err_total", n_err, 3);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
